// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack.
//   STACK_WIDTH / STACK_DEPTH : default word width and entry count, shared with
//                               the CPU top and the bench.
//   stack_op_t                : decoded {push, pop} strobe pair.
//   decode_op()               : maps the raw strobes onto stack_op_t.
package stack_pkg;

  localparam int unsigned STACK_WIDTH = 8;
  localparam int unsigned STACK_DEPTH = 16;

  // Encoding is exactly {push, pop}, so decoding is a plain cast.
  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_t;

  function automatic stack_op_t decode_op(logic push, logic pop);
    return stack_op_t'({push, pop});
  endfunction

endpackage

// File: rtl/stack_unit_if.sv
// Controller <-> operand stack connection.
//   master : controller side (drives push/pop/din/clr_err, reads status).
//   slave  : stack side (reads strobes, drives dout/status/errors).
// Optional: STACK_PEEK_EN adds the next-on-stack word 'nos'.
interface stack_unit_if
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = STACK_WIDTH,
  parameter int unsigned DEPTH = STACK_DEPTH
);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic [CNTW-1:0]  count;
  logic             overflow_err;
  logic             underflow_err;
`ifdef STACK_PEEK_EN
  logic [WIDTH-1:0] nos;
`endif

  modport master (
    output push, pop, din, clr_err,
`ifdef STACK_PEEK_EN
    input  nos,
`endif
    input  dout, empty, full, count, overflow_err, underflow_err
  );

  modport slave (
    input  push, pop, din, clr_err,
`ifdef STACK_PEEK_EN
    output nos,
`endif
    output dout, empty, full, count, overflow_err, underflow_err
  );

endinterface

// File: rtl/stack_ram.sv
// DEPTH x WIDTH register file for the operand stack. No reset on contents.
//   clk_i                  : write clock
//   we_i/waddr_i/wdata_i   : synchronous write port
//   raddr_a_i/rdata_a_o    : combinational read port A
//   raddr_b_i/rdata_b_o    : combinational read port B
module stack_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_a_i,
  output logic [WIDTH-1:0] rdata_a_o,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_b_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/stack_unit.sv
// Operand stack for the stack CPU: LIFO of WIDTH-bit words with a registered
// top-of-stack, full/empty/count status and sticky overflow/underflow flags.
//   clk    : system clock, rising edge
//   rst    : asynchronous active-low reset
//   bus_io : stack_unit_if slave (push/pop/din/clr_err in; dout/empty/full/
//            count/overflow_err/underflow_err out)
// Optional: STACK_PEEK_EN adds a registered next-on-stack output (bus_io.nos).
module stack_unit
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = STACK_WIDTH,
  parameter int unsigned DEPTH = STACK_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  stack_unit_if.slave  bus_io
);

  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [CNTW-1:0] SpFull = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] SpOne  = CNTW'(1);

  logic [CNTW-1:0]  sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
`ifdef STACK_PEEK_EN
  logic [WIDTH-1:0] nos_q, nos_d;
`endif

  stack_op_t        op;
  logic             is_empty, is_full, do_push;
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [WIDTH-1:0] rd_a, rd_b;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == SpFull);

  // Reads are addressed for the post-pop stack: A is the new top (sp-2) and
  // B the entry below it (sp-3), so a pop can reload dout/nos in one edge.
  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i     (clk),
    .we_i      (ram_we),
    .waddr_i   (ram_waddr),
    .wdata_i   (bus_io.din),
    .raddr_a_i (AW'(sp_q - CNTW'(2))),
    .rdata_a_o (rd_a),
    .raddr_b_i (AW'(sp_q - CNTW'(3))),
    .rdata_b_o (rd_b)
  );

  always_comb begin
    op        = decode_op(bus_io.push, bus_io.pop);
    sp_d      = sp_q;
    dout_d    = dout_q;
    ovf_d     = bus_io.clr_err ? 1'b0 : ovf_q;
    unf_d     = bus_io.clr_err ? 1'b0 : unf_q;
    do_push   = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = AW'(sp_q);
`ifdef STACK_PEEK_EN
    nos_d     = nos_q;
`endif

    unique case (op)
      OP_NOP: ;
      OP_PUSH: begin
        if (is_full) ovf_d = 1'b1;
        else         do_push = 1'b1;
      end
      OP_POP: begin
        if (is_empty) begin
          unf_d = 1'b1;
        end else if (sp_q == SpOne) begin
          sp_d   = '0;
          dout_d = '0;
`ifdef STACK_PEEK_EN
          nos_d  = '0;
`endif
        end else begin
          sp_d   = sp_q - SpOne;
          dout_d = rd_a;
`ifdef STACK_PEEK_EN
          nos_d  = (sp_q > CNTW'(2)) ? rd_b : '0;
`endif
        end
      end
      OP_REPLACE: begin
        // Overwrite the top in place; on an empty stack this is a push.
        if (is_empty) begin
          do_push = 1'b1;
        end else begin
          ram_we    = 1'b1;
          ram_waddr = AW'(sp_q - SpOne);
          dout_d    = bus_io.din;
        end
      end
    endcase

    if (do_push) begin
      ram_we    = 1'b1;
      ram_waddr = AW'(sp_q);
      sp_d      = sp_q + SpOne;
      dout_d    = bus_io.din;
`ifdef STACK_PEEK_EN
      nos_d     = dout_q;  // old top (0 when empty) slides down
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q   <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
`ifdef STACK_PEEK_EN
      nos_q  <= '0;
`endif
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
`ifdef STACK_PEEK_EN
      nos_q  <= nos_d;
`endif
    end
  end

`ifndef STACK_PEEK_EN
  logic unused_rd_b;
  assign unused_rd_b = ^rd_b;
`endif

  assign bus_io.dout          = dout_q;
  assign bus_io.empty         = is_empty;
  assign bus_io.full          = is_full;
  assign bus_io.count         = sp_q;
  assign bus_io.overflow_err  = ovf_q;
  assign bus_io.underflow_err = unf_q;
`ifdef STACK_PEEK_EN
  assign bus_io.nos           = nos_q;
`endif

endmodule
